// File: rtl/mem_stage_cache.sv
// Memory-stage data cache: direct-mapped, one 16-bit word per line,
// write-through, no-write-allocate, in front of an asynchronous 16-bit SRAM.
// Read hits complete combinationally. Misses and all writes raise mem_stall
// until the SRAM access finishes.
module mem_stage_cache #(
  parameter int INDEX_W   = 6,
  parameter int SRAM_WAIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        mem_stall,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_UB_N_O,
  output logic        SRAM_LB_N_O,
  output logic        SRAM_CE_N_O,
  output logic        SRAM_WE_N_O,
  output logic        SRAM_OE_N_O,
  input  logic [3:0]  monitor_sel,
  output logic [15:0] monitor_data
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 16 - INDEX_W;
  localparam int CNT_W = (SRAM_WAIT > 8) ? $clog2(SRAM_WAIT) : 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [15:0]        data_q [LINES];

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic               cnt_last_s;
  logic               fill_s;      // read-miss completion: load line from SRAM
  logic               wr_upd_s;    // write-hit completion: refresh line data
  logic               dq_oe_s;
  logic [15:0]        line_data_d;
  logic [TAG_W-1:0]   line_tag_d;
  logic [INDEX_W-1:0] mon_idx_s;

  assign idx_s      = addr[INDEX_W-1:0];
  assign tag_s      = addr[15:INDEX_W];
  assign hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign cnt_last_s = (cnt_q == CNT_W'(SRAM_WAIT - 1));

  // Address is passed live: EX/MEM is frozen while the access is in flight.
  assign SRAM_ADDR   = {2'b00, addr};
  assign SRAM_UB_N_O = 1'b0;
  assign SRAM_LB_N_O = 1'b0;
  assign SRAM_CE_N_O = 1'b0;
  // The data bus is only ever driven during write-through, when OE_N is high.
  assign SRAM_DQ     = dq_oe_s ? wr_data : 16'hzzzz;

  // Next-state, counter, line-update strobes and bus/pipeline controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    fill_s      = 1'b0;
    wr_upd_s    = 1'b0;
    mem_stall   = 1'b0;
    rd_data     = 16'h0000;
    SRAM_WE_N_O = 1'b1;
    SRAM_OE_N_O = 1'b1;
    dq_oe_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          mem_stall = 1'b1;
          state_d   = WR_THRU;
          cnt_d     = '0;
        end else if (mem_read) begin
          if (hit_s) begin
            rd_data = data_q[idx_s];
          end else begin
            mem_stall = 1'b1;
            state_d   = RD_MISS;
            cnt_d     = '0;
          end
        end else begin
          rd_data = 16'h0000;
        end
      end
      RD_MISS: begin
        mem_stall   = 1'b1;
        SRAM_OE_N_O = 1'b0;
        if (cnt_last_s) begin
          fill_s         = 1'b1;
          valid_d[idx_s] = 1'b1;
          state_d        = IDLE;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_THRU: begin
        mem_stall   = 1'b1;
        SRAM_WE_N_O = 1'b0;
        dq_oe_s     = 1'b1;
        if (cnt_last_s) begin
          wr_upd_s = hit_s;
          state_d  = WR_DONE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_DONE: begin
        // One non-stalled cycle so the store retires exactly once.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset overrides everything: quiet bus, no stall, no line update.
    if (rst) begin
      mem_stall   = 1'b0;
      rd_data     = 16'h0000;
      SRAM_WE_N_O = 1'b1;
      SRAM_OE_N_O = 1'b1;
      dq_oe_s     = 1'b0;
      fill_s      = 1'b0;
      wr_upd_s    = 1'b0;
    end else begin
      dq_oe_s = dq_oe_s;
    end
  end

  // Data/tag to be written into the addressed line (kept apart from the
  // control decode so the bus read does not feed back into the drive enable).
  always_comb begin
    line_data_d = data_q[idx_s];
    line_tag_d  = tag_q[idx_s];
    if (fill_s) begin
      line_data_d = SRAM_DQ;
      line_tag_d  = tag_s;
    end else if (wr_upd_s) begin
      line_data_d = wr_data;
    end else begin
      line_data_d = data_q[idx_s];
    end
  end

  // Debug view of one line; invalid lines read as zero.
  always_comb begin
    mon_idx_s = INDEX_W'(monitor_sel);
    if (valid_q[mon_idx_s]) begin
      monitor_data = data_q[mon_idx_s];
    end else begin
      monitor_data = 16'h0000;
    end
  end

  // FSM state, wait counter and valid bits with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Line data/tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_s || wr_upd_s) begin
      data_q[idx_s] <= line_data_d;
      tag_q[idx_s]  <= line_tag_d;
    end
  end

endmodule
